// File: rtl/obstacle_queue.sv
// obstacle_queue: ring buffer of cactus obstacles kept in 11-bit world coordinates.
// New cacti spawn a pseudo-random distance apart, ahead of the visible screen, and
// the oldest one retires after scrolling fully past the left edge. Head and indexed
// read ports give screen-relative x positions to collision and rendering logic.

module obstacle_queue #(
  parameter int          SLOTS     = 4,
  parameter int          SCREEN_W  = 640,
  parameter int          CACTUS_W  = 24,
  parameter int          MIN_GAP   = 200,
  parameter int          GAP_MASK  = 255,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic [10:0]              pos,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic [10:0]              rd_x,
  output logic [1:0]               rd_type,
  output logic                     rd_valid,
  output logic [10:0]              head_x,
  output logic [1:0]               head_type,
  output logic                     head_valid,
  output logic [$clog2(SLOTS):0]   count,
  output logic                     spawn_pulse
);

  localparam int            PW         = $clog2(SLOTS);
  localparam logic [15:0]   SEED       = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [10:0]   SCREEN_W_V = 11'(SCREEN_W);
  localparam logic [10:0]   CACTUS_W_V = 11'(CACTUS_W);
  localparam logic [10:0]   MIN_GAP_V  = 11'(MIN_GAP);
  localparam logic [7:0]    GAP_MASK_V = 8'(GAP_MASK);
  localparam logic [PW:0]   SLOTS_V    = (PW+1)'(SLOTS);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_next;
  logic [15:0]   lfsr, lfsr_next, lfsr_step;
  logic [10:0]   gap_r, gap_next, gap_new;
  logic [10:0]   last_spawn, last_next;
  logic [PW-1:0] head_ptr, head_next, tail_ptr, tail_next, rd_slot;
  logic [PW:0]   count_next, after_retire;
  logic [10:0]   wx_mem [SLOTS];
  logic [1:0]    type_mem [SLOTS];
  logic [10:0]   behind, since_spawn, spawn_wx;
  logic          retire, spawn;
  logic [10:0]   head_wx_sel, head_x_n, rd_x_n;
  logic [1:0]    head_type_sel, head_type_n, rd_type_n;
  logic          head_valid_n, rd_valid_n;

  // Fibonacci taps 16,14,13,11 shifting left; all distances are modulo 2048
  assign lfsr_step   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign gap_new     = MIN_GAP_V + {3'b000, lfsr[7:0] & GAP_MASK_V};
  assign behind      = pos - wx_mem[head_ptr];
  assign since_spawn = pos - last_spawn;
  assign spawn_wx    = pos + SCREEN_W_V;
  assign spawn_pulse = spawn & ~reset;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: init draws the first gap, run decides spawn/retire unless halted
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    gap_next   = gap_r;
    last_next  = last_spawn;
    head_next  = head_ptr;
    tail_next  = tail_ptr;
    count_next = count;
    retire     = 1'b0;
    spawn      = 1'b0;
    case (state)
      S_INIT: begin
        gap_next   = gap_new;
        lfsr_next  = lfsr_step;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (!halt) begin
          retire    = (count != '0) && (behind >= CACTUS_W_V) && !behind[10];
          spawn     = (since_spawn >= gap_r) && (count < SLOTS_V);
          lfsr_next = lfsr_step;
          if (retire) begin
            head_next = head_ptr + PTR_ONE;
          end
          if (spawn) begin
            tail_next = tail_ptr + PTR_ONE;
            last_next = pos;
            gap_next  = gap_new;
          end
          case ({spawn, retire})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
          endcase
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // Output staging: head after this cycle's update (bypassing a spawn into an empty queue), read port before it
  always_comb begin
    after_retire = retire ? (count - CNT_ONE) : count;
    if (spawn && (after_retire == '0)) begin
      head_wx_sel   = spawn_wx;
      head_type_sel = lfsr[9:8];
    end else begin
      head_wx_sel   = wx_mem[head_next];
      head_type_sel = type_mem[head_next];
    end
    head_valid_n = (count_next != '0);
    head_x_n     = head_valid_n ? (head_wx_sel - pos) : 11'd0;
    head_type_n  = head_valid_n ? head_type_sel : 2'd0;
    rd_slot      = head_ptr + rd_idx;
    rd_valid_n   = ({1'b0, rd_idx} < count);
    rd_x_n       = rd_valid_n ? (wx_mem[rd_slot] - pos) : 11'd0;
    rd_type_n    = rd_valid_n ? type_mem[rd_slot] : 2'd0;
  end

  // Queue bookkeeping, LFSR and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= SEED;
      gap_r      <= MIN_GAP_V;
      last_spawn <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      head_x     <= '0;
      head_type  <= '0;
      head_valid <= 1'b0;
      rd_x       <= '0;
      rd_type    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      lfsr       <= lfsr_next;
      gap_r      <= gap_next;
      last_spawn <= last_next;
      head_ptr   <= head_next;
      tail_ptr   <= tail_next;
      count      <= count_next;
      head_x     <= head_x_n;
      head_type  <= head_type_n;
      head_valid <= head_valid_n;
      rd_x       <= rd_x_n;
      rd_type    <= rd_type_n;
      rd_valid   <= rd_valid_n;
    end
  end

  // Entry storage: a spawn writes world x and variant at the tail slot
  always_ff @(posedge clk) begin
    if (!reset && spawn) begin
      wx_mem[tail_ptr]   <= spawn_wx;
      type_mem[tail_ptr] <= lfsr[9:8];
    end
  end

endmodule

// File: tb/tb_obstacle_queue.sv
// tb_obstacle_queue: drives obstacle_queue cycle by cycle, predicts every output
// with a queue-based behavioural model, and checks hand-derived corner vectors.

module tb_obstacle_queue;

  localparam int          SLOTS    = 4;
  localparam int          SCREEN_W = 640;
  localparam int          CACTUS_W = 24;
  localparam int          MIN_GAP  = 200;
  localparam int          GAP_MASK = 0;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          NV       = 18;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic [10:0] pos;
  logic [1:0]  rd_idx;
  logic [10:0] rd_x, head_x;
  logic [1:0]  rd_type, head_type;
  logic        rd_valid, head_valid, spawn_pulse;
  logic [2:0]  count;

  obstacle_queue #(
    .SLOTS(SLOTS), .SCREEN_W(SCREEN_W), .CACTUS_W(CACTUS_W),
    .MIN_GAP(MIN_GAP), .GAP_MASK(GAP_MASK), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .pos(pos), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_type(rd_type), .rd_valid(rd_valid),
    .head_x(head_x), .head_type(head_type), .head_valid(head_valid),
    .count(count), .spawn_pulse(spawn_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spawn;
    int          count;
    logic [10:0] head_x;
    logic [1:0]  head_type;
    logic        head_valid;
    logic [10:0] rd_x;
    logic [1:0]  rd_type;
    logic        rd_valid;
  } exp_t;

  typedef struct {
    logic [10:0] wx;
    logic [1:0]  typ;
  } ent_t;

  typedef struct {
    logic        rst;
    logic [10:0] pos;
    logic [1:0]  idx;
    logic        spawn;
    int          count;
    logic        hv;
    logic [10:0] hx;
    logic        rv;
    logic [10:0] rx;
  } vec_t;

  exp_t        sb[$];
  ent_t        mq[$];
  int          spawn_at[$];
  vec_t        tbl[NV];
  logic [15:0] m_lfsr;
  logic [10:0] m_gap, m_last;
  bit          m_init;
  logic        seen_spawn;
  logic [1:0]  exp_type0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [15:0] lfsrAdv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [10:0] gapFrom(input logic [15:0] v);
    return 11'(MIN_GAP) + {3'b000, v[7:0] & 8'(GAP_MASK)};
  endfunction

  function automatic vec_t mkVec(input int r, input int p, input int idx, input int sp,
                                 input int cnt, input int hv, input int hx, input int rv, input int rx);
    vec_t v;
    v.rst = r[0]; v.pos = p[10:0]; v.idx = idx[1:0]; v.spawn = sp[0]; v.count = cnt;
    v.hv = hv[0]; v.hx = hx[10:0]; v.rv = rv[0]; v.rx = rx[10:0];
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one clock cycle: returns pre-edge spawn and post-edge outputs
  task automatic modelStep(input logic r, input logic h, input logic [10:0] p,
                           input logic [1:0] idx, output exp_t e);
    logic [10:0] behind, since;
    bit          ret, spn;
    ent_t        ne;
    e.spawn = 1'b0; e.count = 0; e.head_x = '0; e.head_type = '0; e.head_valid = 1'b0;
    e.rd_x = '0; e.rd_type = '0; e.rd_valid = 1'b0;
    ne.wx = '0; ne.typ = '0;
    if (r) begin
      mq.delete();
      m_lfsr = SEED;
      m_last = '0;
      m_gap  = '0;
      m_init = 1'b1;
    end else begin
      if (int'(idx) < mq.size()) begin
        e.rd_valid = 1'b1;
        e.rd_x     = mq[idx].wx - p;
        e.rd_type  = mq[idx].typ;
      end
      if (m_init) begin
        m_gap  = gapFrom(m_lfsr);
        m_lfsr = lfsrAdv(m_lfsr);
        m_init = 1'b0;
      end else if (!h) begin
        ret = 1'b0;
        if (mq.size() > 0) begin
          behind = p - mq[0].wx;
          ret = (int'(behind) >= CACTUS_W) && (int'(behind) <= 1023);
        end
        since = p - m_last;
        spn = (since >= m_gap) && (mq.size() < SLOTS);
        if (spn) begin
          ne.wx  = p + 11'(SCREEN_W);
          ne.typ = m_lfsr[9:8];
          m_last = p;
          m_gap  = gapFrom(m_lfsr);
        end
        if (ret) mq.delete(0);
        if (spn) mq.push_back(ne);
        m_lfsr  = lfsrAdv(m_lfsr);
        e.spawn = spn;
      end
      e.count = mq.size();
      if (mq.size() > 0) begin
        e.head_valid = 1'b1;
        e.head_x     = mq[0].wx - p;
        e.head_type  = mq[0].typ;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    cmp("spawn_pulse", seen_spawn, e.spawn);
    cmp("count", count, e.count);
    cmp("head_valid", head_valid, e.head_valid);
    cmp("head_x", head_x, e.head_x);
    cmp("head_type", head_type, e.head_type);
    cmp("rd_valid", rd_valid, e.rd_valid);
    cmp("rd_x", rd_x, e.rd_x);
    cmp("rd_type", rd_type, e.rd_type);
  endtask

  // One cycle: drive, predict into the scoreboard, sample the pulse mid-cycle, check after the edge
  task automatic applyStimulus(input logic r, input logic h, input logic [10:0] p, input logic [1:0] idx);
    exp_t e;
    reset  = r;
    halt   = h;
    pos    = p;
    rd_idx = idx;
    modelStep(r, h, p, idx, e);
    sb.push_back(e);
    @(negedge clk);
    seen_spawn = spawn_pulse;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkRampSpawns(input string tag);
    for (int j = 0; j < 3; j++) begin
      cmp($sformatf("%s_spawn%0d_pos", tag, j),
          (j < spawn_at.size()) ? spawn_at[j] : -1, 200 * (j + 1));
    end
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1; halt = 1'b0; pos = '0; rd_idx = '0; seen_spawn = 1'b0;

    v = SEED;
    for (int i = 0; i < 100; i++) v = lfsrAdv(v);
    exp_type0 = v[9:8];

    tbl[0]  = mkVec(1,    0, 0, 0, 0, 0,    0, 0,    0);
    tbl[1]  = mkVec(0,    0, 0, 0, 0, 0,    0, 0,    0);
    tbl[2]  = mkVec(0,  200, 0, 1, 1, 1,  640, 0,    0);
    tbl[3]  = mkVec(0,  400, 0, 1, 2, 1,  440, 1,  440);
    tbl[4]  = mkVec(0,  600, 1, 1, 3, 1,  240, 1,  440);
    tbl[5]  = mkVec(0,  800, 2, 1, 4, 1,   40, 1,  440);
    tbl[6]  = mkVec(0, 1900, 3, 0, 4, 1,  988, 1, 1588);
    tbl[7]  = mkVec(0, 1900, 0, 0, 4, 1,  988, 1,  988);
    tbl[8]  = mkVec(0,  862, 0, 0, 4, 1, 2026, 1, 2026);
    tbl[9]  = mkVec(0,  864, 0, 0, 3, 1,  176, 1, 2024);
    tbl[10] = mkVec(0, 1000, 0, 1, 4, 1,   40, 1,   40);
    tbl[11] = mkVec(0, 1200, 0, 0, 3, 1,   40, 1, 1888);
    tbl[12] = mkVec(0, 1202, 3, 1, 4, 1,   38, 0,    0);
    tbl[13] = mkVec(0, 1202, 3, 0, 4, 1,   38, 1,  640);
    tbl[14] = mkVec(0, 1264, 0, 0, 3, 1,  176, 1, 2024);
    tbl[15] = mkVec(0, 1464, 0, 1, 3, 1,  176, 1, 2024);
    tbl[16] = mkVec(0, 2000, 2, 1, 3, 1, 1890, 1,  104);
    tbl[17] = mkVec(0,  200, 2, 1, 3, 1, 1904, 1,  392);

    @(posedge clk);
    #1;

    $display("[TB] idle: pos held at zero");
    applyStimulus(1'b1, 1'b0, 11'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 11'd0, 2'd0);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b0, 11'd0, 2'(i));
    cmp("idle_head_valid", head_valid, 0);
    cmp("idle_count", count, 0);

    $display("[TB] vector table: fill, full deferral, retire edge, wrap");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i].rst, 1'b0, tbl[i].pos, tbl[i].idx);
      cmp($sformatf("v%0d_spawn", i), seen_spawn, tbl[i].spawn);
      cmp($sformatf("v%0d_count", i), count, tbl[i].count);
      cmp($sformatf("v%0d_head_valid", i), head_valid, tbl[i].hv);
      cmp($sformatf("v%0d_head_x", i), head_x, tbl[i].hx);
      cmp($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].rv);
      cmp($sformatf("v%0d_rd_x", i), rd_x, tbl[i].rx);
    end

    $display("[TB] ramp: pos +2 per cycle from reset");
    applyStimulus(1'b1, 1'b0, 11'd0, 2'd0);
    spawn_at.delete();
    for (int k = 0; k <= 700; k++) begin
      applyStimulus(1'b0, 1'b0, 11'(2 * k), 2'(k));
      if (seen_spawn) spawn_at.push_back(2 * k);
      if (k == 150) begin
        cmp("ramp_head_x_at_300", head_x, 540);
        cmp("ramp_head_type_at_300", head_type, exp_type0);
      end
    end
    cmp("ramp_spawn_total", spawn_at.size(), 7);
    checkRampSpawns("ramp");

    $display("[TB] halt while scrolling, then reset under halt");
    for (int k = 0; k < 200; k++) applyStimulus(1'b0, 1'b1, 11'(1402 + 2 * k), 2'(k));
    cmp("halt_count_frozen", count, 4);
    applyStimulus(1'b1, 1'b1, 11'd1802, 2'd0);
    cmp("halt_reset_count", count, 0);
    cmp("halt_reset_head_valid", head_valid, 0);

    $display("[TB] restart ramp after reset");
    spawn_at.delete();
    for (int k = 0; k <= 650; k++) begin
      applyStimulus(1'b0, 1'b0, 11'(2 * k), 2'(k));
      if (seen_spawn) spawn_at.push_back(2 * k);
      if (k == 150) cmp("restart_head_type_at_300", head_type, exp_type0);
    end
    checkRampSpawns("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
